// File: rtl/miriscv_pkg.sv
// Shared definitions for the miriscv data-memory responder: bus widths,
// FSM state encoding and address helpers.
package miriscv_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    // The address is compared against the base before subtracting, so an
    // address below the base can never wrap around into the valid window.
    function automatic logic addr_in_range(input logic [XLEN-1:0] addr,
                                           input logic [XLEN-1:0] base,
                                           input logic [XLEN-1:0] depth_words);
        return (addr >= base) && (((addr - base) >> 2) < depth_words);
    endfunction

    function automatic logic [XLEN-1:0] word_index(input logic [XLEN-1:0] addr,
                                                   input logic [XLEN-1:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/miriscv_dmem_array.sv
// Synchronous byte-enable RAM, DEPTH_WORDS x 32, with one registered read
// port and one byte-lane write port.
module miriscv_dmem_array
    import miriscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic              clk_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [XLEN-1:0]   rdata_o,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [XLEN-1:0]   wdata_i
);

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];
    logic [XLEN-1:0] rdata_q;

    // NOTE: storage has no reset; contents survive rst_n and map onto RAM macros.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/miriscv_dmem_rsp.sv
// Data-memory responder for the LSU: grants one request at a time, waits
// WAIT_CYCLES, then returns a single-cycle response with data or error.
module miriscv_dmem_rsp
    import miriscv_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);

    dmem_state_e       state_q;
    logic [3:0]        cnt_q;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic              err_q;
    logic              rvalid_q;

    logic              ram_re;
    logic              ram_we;
    logic [XLEN-1:0]   rd_addr;
    logic [XLEN-1:0]   ram_rdata;

    // Reset gates the grant so nothing is accepted while rst_n_i is low.
    assign data_gnt_o = data_req_i & rst_n_i & (state_q == IDLE);

    // The RAM read is launched in the cycle before RESP; with no wait states
    // that is the grant cycle itself, so the live address is used there.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_addr = addr_q;
        ram_re  = 1'b0;
        if (state_q == IDLE) begin
            rd_addr = data_addr_i;
            ram_re  = (WAIT_CYCLES == 0) && data_gnt_o;
        end else if (state_q == WAIT) begin
            ram_re  = (cnt_q == 4'd0);
        end
    end

    assign ram_we = (state_q == RESP) & we_q & ~err_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rvalid_q <= 1'b0;
                    if (data_gnt_o) begin
                        we_q    <= data_we_i;
                        be_q    <= data_be_i;
                        addr_q  <= data_addr_i;
                        wdata_q <= data_wdata_i;
                        err_q   <= ~addr_in_range(data_addr_i, BASE_ADDR, DEPTH_W32);
                        if (WAIT_CYCLES > 0) begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_LOAD;
                        end else begin
                            state_q  <= RESP;
                            rvalid_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= RESP;
                        rvalid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q  <= IDLE;
                    rvalid_q <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    rvalid_q <= 1'b0;
                end
            endcase
        end
    end

    miriscv_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .re_i    (ram_re),
        .raddr_i (IDX_W'(word_index(rd_addr, BASE_ADDR))),
        .rdata_o (ram_rdata),
        .we_i    (ram_we),
        .be_i    (be_q),
        .waddr_i (IDX_W'(word_index(addr_q, BASE_ADDR))),
        .wdata_i (wdata_q)
    );

    assign data_rvalid_o = rvalid_q;
    assign data_err_o    = rvalid_q & err_q;
    assign data_rdata_o  = (rvalid_q && !err_q && !we_q) ? ram_rdata : '0;

endmodule
